// File: rtl/specialist_pkg.sv
// Shared types and constants for the Specialist machine support blocks.
// Holds the RKS tape loader state and error encodings.
package specialist_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR,
      ST_DATA,
      ST_CS,
      ST_DONE,
      ST_ERR
   } rks_state_t;

   typedef enum logic [1:0] {
      RKS_OK    = 2'd0,
      RKS_RANGE = 2'd1,
      RKS_SHORT = 2'd2,
      RKS_CSUM  = 2'd3
   } rks_err_t;

   localparam int RKS_HDR_LEN = 4;

endpackage

// File: rtl/rks_csum.sv
// RKS payload checksum: each byte adds b*257, except the last byte,
// which adds only into the low byte with no carry into the high byte.
module rks_csum (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        clr,
   input  logic        en,
   input  logic        last,
   input  logic [7:0]  b,
   output logic [15:0] cs
);

   // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cs <= 16'h0000;
      end else if (clr) begin
         cs <= 16'h0000;
      end else if (en) begin
         if (last) cs[7:0] <= cs[7:0] + b;
         else      cs      <= cs + {b, b};
      end
   end

endmodule

// File: rtl/rks_loader.sv
// Streaming RKS tape image parser: header decode, RAM write-out of the
// payload, and trailing checksum verification on the ioctl download stream.
module rks_loader
   import specialist_pkg::*;
#(
   parameter logic [7:0] INDEX = 8'd1
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [7:0]  ioctl_index,
   input  logic        ioctl_wr,
   input  logic [7:0]  ioctl_dout,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_data,
   output logic        mem_we,
   output logic        busy,
   output logic        done,
   output logic [15:0] exec_addr,
   output logic        error,
   output logic [1:0]  err_code
);

   rks_state_t  state;
   logic        active;
   logic        active_q;
   logic        rise;
   logic        fall;
   logic        strobe;
   logic [2:0]  cnt;
   logic [15:0] start_a;
   logic [15:0] end_a;
   logic [15:0] ptr;
   logic [7:0]  cs_lo;
   logic [15:0] cs;
   logic        csum_en;
   logic        csum_last;

   assign active    = ioctl_download & (ioctl_index == INDEX);
   assign rise      = active & ~active_q;
   assign fall      = ~active & active_q;
   assign strobe    = ioctl_wr & active;
   assign csum_en   = strobe & (state == ST_DATA);
   assign csum_last = (ptr == end_a);

   rks_csum u_csum (
      .clk_sys (clk_sys),
      .reset_n (reset_n),
      .clr     (rise),
      .en      (csum_en),
      .last    (csum_last),
      .b       (ioctl_dout),
      .cs      (cs)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         active_q  <= 1'b0;
         cnt       <= 3'd0;
         start_a   <= 16'h0000;
         end_a     <= 16'h0000;
         ptr       <= 16'h0000;
         cs_lo     <= 8'h00;
         mem_addr  <= 16'h0000;
         mem_data  <= 8'h00;
         mem_we    <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         exec_addr <= 16'h0000;
         error     <= 1'b0;
         err_code  <= RKS_OK;
      end else begin
         active_q <= active;
         // NOTE: pulse outputs default low every cycle; a later assignment in this block wins.
         mem_we   <= 1'b0;
         done     <= 1'b0;

         if (rise) begin
            state    <= ST_HDR;
            cnt      <= 3'd0;
            error    <= 1'b0;
            err_code <= RKS_OK;
            busy     <= 1'b1;
         end else begin
            case (state)
               ST_HDR: begin
                  if (fall) begin
                     state    <= ST_ERR;
                     error    <= 1'b1;
                     err_code <= RKS_SHORT;
                     busy     <= 1'b0;
                  end else if (strobe) begin
                     cnt <= cnt + 3'd1;
                     if (cnt == 3'(RKS_HDR_LEN - 1)) begin
                        end_a[15:8] <= ioctl_dout;
                        if ({ioctl_dout, end_a[7:0]} < start_a) begin
                           state    <= ST_ERR;
                           error    <= 1'b1;
                           err_code <= RKS_RANGE;
                           busy     <= 1'b0;
                        end else begin
                           state <= ST_DATA;
                           ptr   <= start_a;
                        end
                     end else begin
                        case (cnt)
                           3'd0:    start_a[7:0]  <= ioctl_dout;
                           3'd1:    start_a[15:8] <= ioctl_dout;
                           default: end_a[7:0]    <= ioctl_dout;
                        endcase
                     end
                  end
               end

               ST_DATA: begin
                  if (fall) begin
                     state    <= ST_ERR;
                     error    <= 1'b1;
                     err_code <= RKS_SHORT;
                     busy     <= 1'b0;
                  end else if (strobe) begin
                     mem_addr <= ptr;
                     mem_data <= ioctl_dout;
                     mem_we   <= 1'b1;
                     ptr      <= ptr + 16'd1;
                     // Compare, not count, ends the payload so a full 64 KiB image works.
                     if (ptr == end_a) begin
                        state <= ST_CS;
                        cnt   <= 3'd0;
                     end
                  end
               end

               ST_CS: begin
                  if (fall) begin
                     state    <= ST_ERR;
                     error    <= 1'b1;
                     err_code <= RKS_SHORT;
                     busy     <= 1'b0;
                  end else if (strobe) begin
                     if (cnt == 3'd0) begin
                        cs_lo <= ioctl_dout;
                        cnt   <= 3'd1;
                     end else if ({ioctl_dout, cs_lo} == cs) begin
                        state     <= ST_DONE;
                        done      <= 1'b1;
                        exec_addr <= start_a;
                        busy      <= 1'b0;
                     end else begin
                        state    <= ST_ERR;
                        error    <= 1'b1;
                        err_code <= RKS_CSUM;
                        busy     <= 1'b0;
                     end
                  end
               end

               ST_DONE: state <= ST_IDLE;
               ST_ERR:  state <= ST_IDLE;
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule
